pipe_hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage core. Drives the load-enable and bubble/flush controls of the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers.
- Resolves three events: load-use hazards (1-cycle stall plus bubble), taken branches resolved in MEM (flush of the 3 younger stages), and multi-cycle data-memory waits (freeze).
- A memory wait that lasts too long triggers a sticky halt. Saturating stall and flush counters support performance debug.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 25 ++
 rtl/pipe_hazard_ctrl_if.sv | 43 ++++
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 16 +
 rtl/pipe_hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the 5-stage pipeline hazard sequencer: FSM states,
// the $zero register index and the bundle of stage-register controls.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idexe_en;
    logic idexe_bubble;
    logic exmem_en;
    logic exmem_bubble;
    logic memwb_en;
    logic memwb_bubble;
  } stage_ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-status inputs and stage-control outputs of the pipeline sequencer.
// master = pipeline datapath side, slave = the sequencer.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             idexe_memread;
  logic [4:0]       idexe_rt;
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_uses_rt;
  logic             exmem_branch_taken;
  logic             exmem_memreq;
  logic             dmem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idexe_en;
  logic             idexe_bubble;
  logic             exmem_en;
  logic             exmem_bubble;
  logic             memwb_en;
  logic             memwb_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output idexe_memread, idexe_rt, ifid_rs, ifid_rt, ifid_uses_rt,
           exmem_branch_taken, exmem_memreq, dmem_ready,
    input  pc_en, ifid_en, ifid_flush, idexe_en, idexe_bubble,
           exmem_en, exmem_bubble, memwb_en, memwb_bubble,
           halted, stall_cycles, flush_count
  );

  modport slave (
    input  idexe_memread, idexe_rt, ifid_rs, ifid_rt, ifid_uses_rt,
           exmem_branch_taken, exmem_memreq, dmem_ready,
    output pc_en, ifid_en, ifid_flush, idexe_en, idexe_bubble,
           exmem_en, exmem_bubble, memwb_en, memwb_bubble,
           halted, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use comparator: the load in ID/EXE writes a register the IF/ID
// instruction is about to read. Writes to $zero never create a dependency.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       idexe_memread_i,
  input  logic [4:0] idexe_rt_i,
  input  logic [4:0] ifid_rs_i,
  input  logic [4:0] ifid_rt_i,
  input  logic       ifid_uses_rt_i,
  output logic       load_use_o
);
  assign load_use_o = idexe_memread_i && (idexe_rt_i != REG_ZERO) &&
                      ((idexe_rt_i == ifid_rs_i) ||
                       (ifid_uses_rt_i && (idexe_rt_i == ifid_rt_i)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer: stage enables/bubbles for load-use stalls,
// MEM-stage branch flushes and data-memory waits, with timeout halt.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.slave   bus
);
  localparam logic [7:0] TIMEOUT_W = 8'(MEM_TIMEOUT);

  state_e           state_q;
  logic [7:0]       wait_cnt_q;
  logic             halted_q;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             load_use, mem_stall, br_flush;
  stage_ctrl_t      ctrl;

  load_use_detect u_lu (
    .idexe_memread_i (bus.idexe_memread),
    .idexe_rt_i      (bus.idexe_rt),
    .ifid_rs_i       (bus.ifid_rs),
    .ifid_rt_i       (bus.ifid_rt),
    .ifid_uses_rt_i  (bus.ifid_uses_rt),
    .load_use_o      (load_use)
  );

  assign mem_stall = bus.exmem_memreq && !bus.dmem_ready;
  assign br_flush  = bus.exmem_branch_taken;

  // Controls are combinational so a hazard acts in the cycle it is seen.
  always_comb begin
    ctrl = '0;
    if (rst || state_q == HALT) begin
      ctrl = '0;
    end else if (mem_stall) begin
      ctrl.memwb_en     = 1'b1;
      ctrl.memwb_bubble = 1'b1;
    end else if (br_flush) begin
      ctrl.pc_en        = 1'b1;
      ctrl.ifid_en      = 1'b1;
      ctrl.ifid_flush   = 1'b1;
      ctrl.idexe_en     = 1'b1;
      ctrl.idexe_bubble = 1'b1;
      ctrl.exmem_en     = 1'b1;
      ctrl.exmem_bubble = 1'b1;
      ctrl.memwb_en     = 1'b1;
    end else if (load_use) begin
      ctrl.idexe_en     = 1'b1;
      ctrl.idexe_bubble = 1'b1;
      ctrl.exmem_en     = 1'b1;
      ctrl.memwb_en     = 1'b1;
    end else begin
      ctrl.pc_en        = 1'b1;
      ctrl.ifid_en      = 1'b1;
      ctrl.idexe_en     = 1'b1;
      ctrl.exmem_en     = 1'b1;
      ctrl.memwb_en     = 1'b1;
    end
  end

  // wait_cnt holds the number of consecutive stalled cycles already seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: if (mem_stall) begin
          state_q    <= WAIT;
          wait_cnt_q <= 8'd1;
        end
        WAIT: if (!mem_stall) begin
          state_q    <= RUN;
          wait_cnt_q <= '0;
        end else if (wait_cnt_q + 8'd1 == TIMEOUT_W) begin
          state_q    <= HALT;
          halted_q   <= 1'b1;
          wait_cnt_q <= '0;
        end else begin
          wait_cnt_q <= wait_cnt_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!ctrl.pc_en && state_q != HALT && stall_q != '1)
      stall_d = stall_q + CNT_W'(1);
    if (br_flush && !mem_stall && state_q != HALT && flush_q != '1)
      flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pc_en        = ctrl.pc_en;
  assign bus.ifid_en      = ctrl.ifid_en;
  assign bus.ifid_flush   = ctrl.ifid_flush;
  assign bus.idexe_en     = ctrl.idexe_en;
  assign bus.idexe_bubble = ctrl.idexe_bubble;
  assign bus.exmem_en     = ctrl.exmem_en;
  assign bus.exmem_bubble = ctrl.exmem_bubble;
  assign bus.memwb_en     = ctrl.memwb_en;
  assign bus.memwb_bubble = ctrl.memwb_bubble;
  assign bus.halted       = halted_q;
  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a default instance and a CNT_W=4/MEM_TIMEOUT=4
// instance share stimulus and are each checked against a behavioural model.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       memread, uses_rt, br, mreq, rdy;
  logic [4:0] ex_rt, rs, if_rt;

  pipe_hazard_ctrl_if #(.CNT_W(16)) ifa ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  ifb ();

  assign ifa.idexe_memread = memread;       assign ifb.idexe_memread = memread;
  assign ifa.idexe_rt = ex_rt;              assign ifb.idexe_rt = ex_rt;
  assign ifa.ifid_rs = rs;                  assign ifb.ifid_rs = rs;
  assign ifa.ifid_rt = if_rt;               assign ifb.ifid_rt = if_rt;
  assign ifa.ifid_uses_rt = uses_rt;        assign ifb.ifid_uses_rt = uses_rt;
  assign ifa.exmem_branch_taken = br;       assign ifb.exmem_branch_taken = br;
  assign ifa.exmem_memreq = mreq;           assign ifb.exmem_memreq = mreq;
  assign ifa.dmem_ready = rdy;              assign ifb.dmem_ready = rdy;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  pipe_hazard_ctrl #(.MEM_TIMEOUT(4),  .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model state per instance.
  int m_to[2]  = '{16, 4};
  int m_max[2] = '{65535, 15};
  bit m_halt[2];
  int m_run[2];
  int m_stall[2];
  int m_flush[2];

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] ctrl_a();
    return {ifa.pc_en, ifa.ifid_en, ifa.ifid_flush, ifa.idexe_en, ifa.idexe_bubble,
            ifa.exmem_en, ifa.exmem_bubble, ifa.memwb_en, ifa.memwb_bubble};
  endfunction
  function automatic logic [8:0] ctrl_b();
    return {ifb.pc_en, ifb.ifid_en, ifb.ifid_flush, ifb.idexe_en, ifb.idexe_bubble,
            ifb.exmem_en, ifb.exmem_bubble, ifb.memwb_en, ifb.memwb_bubble};
  endfunction

  // Order: pc_en ifid_en ifid_flush idexe_en idexe_bubble exmem_en exmem_bubble memwb_en memwb_bubble
  function automatic logic [8:0] exp_ctrl(input bit halted_now);
    bit ms, lu;
    ms = mreq && !rdy;
    lu = memread && (ex_rt != 0) && (ex_rt == rs || (uses_rt && ex_rt == if_rt));
    if (rst || halted_now) return 9'b000000000;
    if (ms)                return 9'b000000011;
    if (br)                return 9'b111111110;
    if (lu)                return 9'b000111010;
    return 9'b110101010;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_halt[d] = 0; m_run[d] = 0; m_stall[d] = 0; m_flush[d] = 0;
    end
  endtask

  task automatic model_edge();
    logic [8:0] e;
    bit ms;
    ms = mreq && !rdy;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_halt[d] = 0; m_run[d] = 0; m_stall[d] = 0; m_flush[d] = 0;
      end else if (!m_halt[d]) begin
        e = exp_ctrl(0);
        if (!e[8]) m_stall[d] = (m_stall[d] + 1 > m_max[d]) ? m_max[d] : m_stall[d] + 1;
        if (br && !ms) m_flush[d] = (m_flush[d] + 1 > m_max[d]) ? m_max[d] : m_flush[d] + 1;
        if (ms) begin
          m_run[d]++;
          if (m_run[d] == m_to[d]) m_halt[d] = 1;
        end else begin
          m_run[d] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    cmp("a.ctrl",  int'(ctrl_a()), int'(exp_ctrl(m_halt[0])));
    cmp("a.halted", int'(ifa.halted), int'(m_halt[0]));
    cmp("a.stall_cycles", int'(ifa.stall_cycles), m_stall[0]);
    cmp("a.flush_count", int'(ifa.flush_count), m_flush[0]);
    cmp("b.ctrl",  int'(ctrl_b()), int'(exp_ctrl(m_halt[1])));
    cmp("b.halted", int'(ifb.halted), int'(m_halt[1]));
    cmp("b.stall_cycles", int'(ifb.stall_cycles), m_stall[1]);
    cmp("b.flush_count", int'(ifb.flush_count), m_flush[1]);
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step();
    #2;
    check_all();
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_in(input bit mr, input int ert, input int ers, input int eirt,
                        input bit ur, input bit b, input bit mq, input bit rd);
    memread = mr; ex_rt = 5'(ert); rs = 5'(ers); if_rt = 5'(eirt);
    uses_rt = ur; br = b; mreq = mq; rdy = rd;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    bit mr; int ert; int ers; int eirt; bit ur; bit b; bit mq; bit rd;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl[10];

  initial begin
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 1, 9'b110101010}; // idle
    tbl[1] = '{1, 8, 8, 0, 0, 0, 0, 1, 9'b000111010}; // load-use on rs
    tbl[2] = '{1, 0, 0, 0, 1, 0, 0, 1, 9'b110101010}; // $zero exemption
    tbl[3] = '{1, 9, 3, 9, 1, 0, 0, 1, 9'b000111010}; // load-use on rt
    tbl[4] = '{1, 9, 3, 9, 0, 0, 0, 1, 9'b110101010}; // rt not a source
    tbl[5] = '{0, 8, 8, 8, 1, 0, 0, 1, 9'b110101010}; // not a load
    tbl[6] = '{1, 8, 8, 0, 0, 1, 0, 1, 9'b111111110}; // flush beats load-use
    tbl[7] = '{1, 8, 8, 0, 0, 1, 1, 0, 9'b000000011}; // mem stall beats all
    tbl[8] = '{0, 0, 0, 0, 0, 0, 1, 1, 9'b110101010}; // mem ready
    tbl[9] = '{0, 0, 0, 0, 0, 1, 1, 1, 9'b111111110}; // flush with ready mem

    idle();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    cmp("reset.ctrl", int'(ctrl_a()), 0);
    cmp("reset.halted", int'(ifa.halted), 0);
    cmp("reset.stall", int'(ifa.stall_cycles), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_reset();
      set_in(tbl[i].mr, tbl[i].ert, tbl[i].ers, tbl[i].eirt, tbl[i].ur, tbl[i].b, tbl[i].mq, tbl[i].rd);
      #1;
      cmp($sformatf("tbl%0d.ctrl", i), int'(ctrl_a()), int'(tbl[i].exp));
      step();
    end

    // Single load-use stall counted once.
    do_reset();
    set_in(1, 8, 8, 0, 0, 0, 0, 1); step();
    idle(); step();
    cmp("lu.stall_cycles", int'(ifa.stall_cycles), 1);

    // Branch flush wins over a simultaneous load-use.
    do_reset();
    set_in(1, 8, 8, 0, 0, 1, 0, 1); step();
    idle(); step();
    cmp("br.flush_count", int'(ifa.flush_count), 1);
    cmp("br.stall_cycles", int'(ifa.stall_cycles), 0);

    // Three-cycle memory wait then completion.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 0);
      #1;
      cmp("mw.ctrl", int'(ctrl_a()), int'(9'b000000011));
      step();
    end
    set_in(0, 0, 0, 0, 0, 0, 1, 1); step();
    idle(); step();
    cmp("mw.stall_cycles", int'(ifa.stall_cycles), 3);
    cmp("mw.halted", int'(ifa.halted), 0);
    cmp("mw.ctrl_after", int'(ctrl_a()), int'(9'b110101010));

    // Timeout: 16 stalled cycles halt the default instance.
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) step();
    #1;
    cmp("to.halted", int'(ifa.halted), 1);
    cmp("to.ctrl", int'(ctrl_a()), 0);
    step();
    idle();
    #1;
    cmp("to.sticky", int'(ifa.halted), 1);
    cmp("to.stall_frozen", int'(ifa.stall_cycles), 16);
    rst = 1'b1;
    #1;
    cmp("to.async_clear", int'(ifa.halted), 0);
    cmp("to.rst_ctrl", int'(ctrl_a()), 0);
    model_reset();
    step();
    rst = 1'b0;

    // Saturation of the 4-bit counter.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_in(1, 5, 5, 0, 0, 0, 0, 1); step();
      idle(); step();
    end
    #1;
    cmp("sat.b_stall", int'(ifb.stall_cycles), 15);
    cmp("sat.a_stall", int'(ifa.stall_cycles), 20);

    // Randomized traffic against the model, with occasional long waits.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        set_in($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 9) < 2,
               $urandom_range(0, 9) < 5, $urandom_range(0, 9) < 6);
        if ($urandom_range(0, 9) < 2) begin
          mreq = 1'b1; rdy = 1'b0;
        end
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
